multicycle_control_fsm: RTL and testbench

- Multi-cycle sequencer for the MIPS datapath: PC, instruction memory/IR, register file, ALU, data memory.
- Replaces the single-cycle opcode decoder. It steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB states, drives every datapath mux and write enable, and waits on a memory-ready handshake.
- It detects illegal opcodes and memory timeouts and halts, and it counts retired instructions.

---
 rtl/multicycle_control_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle MIPS control sequencer with memory handshake, error halt and retire counter
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       wait_inc;
  logic             end_instr;
  logic             mem_wait;

  // Branch resolution happens in the datapath; the sequencer never looks at Zero.
  logic zero_unused;
  assign zero_unused = Zero;

  assign wait_inc    = wait_q + 8'd1;
  assign state       = state_q;
  assign halted      = (state_q == S_HALT);
  assign err_code    = err_q;
  assign instr_count = cnt_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      err_q   <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    err_d       = err_q;
    cnt_d       = cnt_q;
    end_instr   = 1'b0;
    mem_wait    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;

    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = 2'b01;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
        mem_wait = 1'b1;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          6'd0:         state_d = S_EXEC_R;
          6'd35, 6'd43: state_d = S_MEM_ADDR;
          6'd4:         state_d = S_BRANCH;
          6'd8:         state_d = S_ADDI_EX;
          6'd2:         state_d = S_JUMP;
          default: begin
            state_d = S_HALT;
            err_d   = 2'b01;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == 6'd35) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MemRead  = 1'b1;
        IorD     = 1'b1;
        mem_wait = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        end_instr = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        mem_wait  = 1'b1;
        end_instr = mem_ready;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        end_instr = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        end_instr   = 1'b1;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite  = 1'b1;
        end_instr = 1'b1;
      end
      S_JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b10;
        end_instr = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // A completing access (mem_ready=1) always beats the timeout on the same cycle.
    if (mem_wait && !mem_ready) begin
      if (wait_inc == TIMEOUT_LIM) begin
        state_d = S_HALT;
        err_d   = 2'b10;
      end else begin
        wait_d = wait_inc;
      end
    end

    if (end_instr) begin
      cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      state_d = run ? S_FETCH : S_IDLE;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        run = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegWrite, RegDst, ALUSrcA;
  logic [1:0]  PCSource, ALUSrcB, ALUOp;
  logic [3:0]  state;
  logic        halted;
  logic [1:0]  err_code;
  logic [31:0] instr_count;
  logic [15:0] ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control_fsm #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .run(run), .opcode(opcode), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .state(state), .halted(halted), .err_code(err_code),
    .instr_count(instr_count)
  );

  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                 MemtoReg, RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUOp};

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut();
    RESET = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = 6'd0; Zero = 1'b0;
    step();
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    repeat (5) step();
    n_tests++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d expected 0", state); end
    n_tests++; if (ctrl !== 16'h0) begin n_fail++; $display("FAIL reset_ctrl got %h expected 0000", ctrl); end
    n_tests++; if (instr_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got %0d expected 0", instr_count); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b expected 0", halted); end
    n_tests++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b expected 00", err_code); end
    run = 1'b1;
    step();
    n_tests++; if (state !== 4'd1) begin n_fail++; $display("FAIL run_to_fetch got %0d expected 1", state); end
    n_tests++; if (MemRead !== 1'b1) begin n_fail++; $display("FAIL fetch_memread got %b expected 1", MemRead); end
  endtask

  task automatic test_rtype();
    int st_tab[5] = '{1, 2, 7, 8, 1};
    reset_dut();
    run = 1'b1; mem_ready = 1'b1; opcode = 6'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++; if (state !== 4'(st_tab[i])) begin n_fail++; $display("FAIL rtype_state[%0d] got %0d expected %0d", i, state, st_tab[i]); end
      n_tests++; if (RegWrite !== (st_tab[i] == 8)) begin n_fail++; $display("FAIL rtype_regwrite[%0d] got %b expected %b", i, RegWrite, st_tab[i] == 8); end
      n_tests++; if (RegDst !== (st_tab[i] == 8)) begin n_fail++; $display("FAIL rtype_regdst[%0d] got %b expected %b", i, RegDst, st_tab[i] == 8); end
      if (i == 0) begin
        n_tests++; if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin n_fail++; $display("FAIL rtype_fetch_wr got %b%b expected 11", IRWrite, PCWrite); end
      end
    end
    n_tests++; if (instr_count !== 32'd1) begin n_fail++; $display("FAIL rtype_count got %0d expected 1", instr_count); end
  endtask

  task automatic test_lw_wait();
    int   st_tab[9] = '{1, 2, 3, 4, 4, 4, 4, 5, 1};
    logic mr_tab[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int   m2r = 0;
    int   rw = 0;
    reset_dut();
    run = 1'b1; mem_ready = 1'b1; opcode = 6'd35;
    for (int i = 0; i < 9; i++) begin
      step();
      n_tests++; if (state !== 4'(st_tab[i])) begin n_fail++; $display("FAIL lw_state[%0d] got %0d expected %0d", i, state, st_tab[i]); end
      mem_ready = mr_tab[i];
      #1;
      m2r += int'(MemtoReg);
      rw  += int'(RegWrite);
      if (st_tab[i] == 4) begin
        n_tests++; if (IorD !== 1'b1 || MemRead !== 1'b1) begin n_fail++; $display("FAIL lw_memrd_ctrl[%0d] got %b%b expected 11", i, IorD, MemRead); end
      end
    end
    n_tests++; if (m2r != 1) begin n_fail++; $display("FAIL lw_memtoreg_cycles got %0d expected 1", m2r); end
    n_tests++; if (rw != 1) begin n_fail++; $display("FAIL lw_regwrite_cycles got %0d expected 1", rw); end
    n_tests++; if (instr_count !== 32'd1) begin n_fail++; $display("FAIL lw_count got %0d expected 1", instr_count); end
  endtask

  task automatic test_beq();
    int   st_tab[7] = '{1, 2, 9, 1, 2, 9, 1};
    logic z_tab[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    reset_dut();
    run = 1'b1; mem_ready = 1'b1; opcode = 6'd4;
    for (int i = 0; i < 7; i++) begin
      step();
      n_tests++; if (state !== 4'(st_tab[i])) begin n_fail++; $display("FAIL beq_state[%0d] got %0d expected %0d", i, state, st_tab[i]); end
      Zero = z_tab[i];
      #1;
      if (st_tab[i] == 9) begin
        n_tests++; if (PCWriteCond !== 1'b1 || PCSource !== 2'b01) begin n_fail++; $display("FAIL beq_ctrl[%0d] got %b/%b expected 1/01", i, PCWriteCond, PCSource); end
      end
    end
    n_tests++; if (instr_count !== 32'd2) begin n_fail++; $display("FAIL beq_count got %0d expected 2", instr_count); end
  endtask

  task automatic test_illegal();
    reset_dut();
    run = 1'b1; mem_ready = 1'b1; opcode = 6'd63;
    repeat (3) step();
    n_tests++; if (state !== 4'd15) begin n_fail++; $display("FAIL illegal_state got %0d expected 15", state); end
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL illegal_halted got %b expected 1", halted); end
    n_tests++; if (err_code !== 2'b01) begin n_fail++; $display("FAIL illegal_err got %b expected 01", err_code); end
    n_tests++; if (ctrl !== 16'h0) begin n_fail++; $display("FAIL illegal_ctrl got %h expected 0000", ctrl); end
    repeat (5) step();
    n_tests++; if (state !== 4'd15) begin n_fail++; $display("FAIL halt_sticky got %0d expected 15", state); end
    #2;
    RESET = 1'b0;
    #1;
    n_tests++; if (state !== 4'd0 || halted !== 1'b0 || err_code !== 2'b00) begin n_fail++; $display("FAIL async_reset got %0d/%b/%b expected 0/0/00", state, halted, err_code); end
    RESET = 1'b1;
  endtask

  task automatic test_timeout();
    reset_dut();
    run = 1'b1; mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (IRWrite !== 1'b0) begin n_fail++; $display("FAIL timeout_irwrite[%0d] got %b expected 0", i, IRWrite); end
      step();
      n_tests++; if (state !== ((i < 3) ? 4'd1 : 4'd15)) begin n_fail++; $display("FAIL timeout_state[%0d] got %0d expected %0d", i, state, (i < 3) ? 1 : 15); end
    end
    n_tests++; if (err_code !== 2'b10) begin n_fail++; $display("FAIL timeout_err got %b expected 10", err_code); end
    reset_dut();
    run = 1'b1; mem_ready = 1'b0;
    step();
    repeat (3) step();
    n_tests++; if (state !== 4'd1) begin n_fail++; $display("FAIL ready_limit_wait got %0d expected 1", state); end
    mem_ready = 1'b1;
    #1;
    n_tests++; if (IRWrite !== 1'b1) begin n_fail++; $display("FAIL ready_limit_irwrite got %b expected 1", IRWrite); end
    step();
    n_tests++; if (state !== 4'd2 || err_code !== 2'b00) begin n_fail++; $display("FAIL ready_limit_decode got %0d/%b expected 2/00", state, err_code); end
  endtask

  task automatic test_back_to_back();
    int   st_tab[12]  = '{1, 2, 10, 11, 1, 2, 12, 1, 2, 3, 6, 0};
    int   op_tab[12]  = '{8, 8, 8, 8, 2, 2, 2, 43, 43, 43, 43, 43};
    logic run_tab[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    reset_dut();
    run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_tests++; if (state !== 4'(st_tab[i])) begin n_fail++; $display("FAIL b2b_state[%0d] got %0d expected %0d", i, state, st_tab[i]); end
      opcode = 6'(op_tab[i]);
      run = run_tab[i];
      #1;
      if (st_tab[i] == 12) begin
        n_tests++; if (PCWrite !== 1'b1 || PCSource !== 2'b10) begin n_fail++; $display("FAIL jump_ctrl got %b/%b expected 1/10", PCWrite, PCSource); end
      end
      if (st_tab[i] == 6) begin
        n_tests++; if (MemWrite !== 1'b1 || IorD !== 1'b1) begin n_fail++; $display("FAIL sw_ctrl got %b/%b expected 1/1", MemWrite, IorD); end
      end
      if (st_tab[i] == 11) begin
        n_tests++; if (RegWrite !== 1'b1 || RegDst !== 1'b0) begin n_fail++; $display("FAIL addi_wb_ctrl got %b/%b expected 1/0", RegWrite, RegDst); end
      end
    end
    n_tests++; if (instr_count !== 32'd3) begin n_fail++; $display("FAIL b2b_count got %0d expected 3", instr_count); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_timeout();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
